f_compress: RTL and testbench

Sequential BLAKE2 compression function F, sitting directly downstream of `f_sched`. It owns the 16-word working vector `v`, drives `f_sched`'s `sub_ctr`/`rnd_ctr`, and uses the returned `a/b/c/d/m0/m1` selections to perform one full G mix per clock. It then folds `v` back into the chaining value and presents the new `h` to the hash-level controller.

---
 rtl/f_compress.sv | 220 ++++++++++++++++++++++
 tb/tb_f_compress.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/f_compress.sv
// BLAKE2 compression function F, one G mix per clock.
//
// f_sched: message/working-vector index schedule for one G step.
//   sub_ctr       in   step within a round (0..3 columns, 4..7 diagonals)
//   rnd_ctr       in   round number (0..11; rounds 10/11 reuse sigma 0/1)
//   a/b/c/d_sel   out  working-vector word indices for this G
//   m0_sel/m1_sel out  message word indices for this G
//
// f_compress: sequential F over a 16-word working vector.
//   clk, rst      in   rising-edge clock, asynchronous active-high reset
//   start         in   request one compression (sampled while idle)
//   h_in, m_in    in   chaining value (8 words), message block (16 words)
//   t_in, f_in    in   byte counter (2 words, low word first), final-block flag
//   busy          out  high exactly while mixing
//   done          out  one-cycle pulse while h_out holds a fresh result
//   h_out         out  new chaining value, held until the next done

module f_sched (
    input  logic [2:0] sub_ctr,
    input  logic [3:0] rnd_ctr,
    output logic [3:0] a_sel,
    output logic [3:0] b_sel,
    output logic [3:0] c_sel,
    output logic [3:0] d_sel,
    output logic [3:0] m0_sel,
    output logic [3:0] m1_sel
);
    logic [3:0]  rnd_mod;
    logic [63:0] row;  // sigma permutation, entry j in nibble j
    logic [1:0]  col;
    logic [1:0]  off;

    always_comb begin
        rnd_mod = (rnd_ctr >= 4'd10) ? (rnd_ctr - 4'd10) : rnd_ctr;
        unique case (rnd_mod)
            4'd0:    row = 64'hFEDCBA9876543210;
            4'd1:    row = 64'h357B20C16DF984AE;
            4'd2:    row = 64'h491763EADF250C8B;
            4'd3:    row = 64'h8F04A562EBCD1397;
            4'd4:    row = 64'hD386CB1EFA427509;
            4'd5:    row = 64'h91EF57D438B0A6C2;
            4'd6:    row = 64'hB8293670A4DEF15C;
            4'd7:    row = 64'hA2684F05931CE7BD;
            4'd8:    row = 64'h5A417D2C803B9EF6;
            4'd9:    row = 64'h0DC3E9BF5167482A;
            default: row = 64'hFEDCBA9876543210;
        endcase
        m0_sel = row[{sub_ctr, 3'b000} +: 4];
        m1_sel = row[{sub_ctr, 3'b100} +: 4];

        // Diagonal steps rotate rows 1..3 left by 1..3 positions.
        col   = sub_ctr[1:0];
        off   = {1'b0, sub_ctr[2]};
        a_sel = {2'b00, col};
        b_sel = {2'b01, col + off};
        c_sel = {2'b10, col + (off << 1)};
        d_sel = {2'b11, col + off + (off << 1)};
    end
endmodule

module f_compress #(
    parameter int unsigned W = 64,
    parameter int unsigned R = 12
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [8*W-1:0]  h_in,
    input  logic [16*W-1:0] m_in,
    input  logic [2*W-1:0]  t_in,
    input  logic            f_in,
    output logic            busy,
    output logic            done,
    output logic [8*W-1:0]  h_out
);
    localparam int unsigned R1 = (W == 64) ? 32 : 16;
    localparam int unsigned R2 = (W == 64) ? 24 : 12;
    localparam int unsigned R3 = (W == 64) ? 16 : 8;
    localparam int unsigned R4 = (W == 64) ? 63 : 7;
    localparam logic [3:0]  LastRnd = 4'(R - 1);

    localparam logic [8*64-1:0] IV64 = {
        64'h5be0cd19137e2179, 64'h1f83d9abfb41bd6b, 64'h9b05688c2b3e6c1f, 64'h510e527fade682d1,
        64'ha54ff53a5f1d36f1, 64'h3c6ef372fe94f82b, 64'hbb67ae8584caa73b, 64'h6a09e667f3bcc908};
    localparam logic [8*32-1:0] IV32 = {
        32'h5be0cd19, 32'h1f83d9ab, 32'h9b05688c, 32'h510e527f,
        32'ha54ff53a, 32'h3c6ef372, 32'hbb67ae85, 32'h6a09e667};

    typedef enum logic [1:0] {StIdle, StMix, StFinal} state_e;

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input int unsigned n);
        return (x >> n) | (x << (W - n));
    endfunction

    state_e               state_q, state_d;
    logic [7:0][W-1:0]    iv_w;
    logic [7:0][W-1:0]    h_q, h_d;
    logic [15:0][W-1:0]   m_q, m_d;
    logic [15:0][W-1:0]   v_q, v_d;
    logic [7:0][W-1:0]    h_out_q, h_out_d;
    logic [2:0]           sub_q, sub_d;
    logic [3:0]           rnd_q, rnd_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [3:0]           a_sel, b_sel, c_sel, d_sel, m0_sel, m1_sel;
    logic [W-1:0]         ga, gb, gc, gd;

    if (W == 64) begin : g_iv64
        assign iv_w = IV64[8*W-1:0];
    end else begin : g_iv32
        assign iv_w = IV32[8*W-1:0];
    end

    f_sched u_sched (
        .sub_ctr (sub_q),
        .rnd_ctr (rnd_q),
        .a_sel   (a_sel),
        .b_sel   (b_sel),
        .c_sel   (c_sel),
        .d_sel   (d_sel),
        .m0_sel  (m0_sel),
        .m1_sel  (m1_sel)
    );

    // Full G on the selected words.
    always_comb begin
        ga = v_q[a_sel];
        gb = v_q[b_sel];
        gc = v_q[c_sel];
        gd = v_q[d_sel];
        ga = ga + gb + m_q[m0_sel];
        gd = rotr(gd ^ ga, R1);
        gc = gc + gd;
        gb = rotr(gb ^ gc, R2);
        ga = ga + gb + m_q[m1_sel];
        gd = rotr(gd ^ ga, R3);
        gc = gc + gd;
        gb = rotr(gb ^ gc, R4);
    end

    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        m_d     = m_q;
        v_d     = v_q;
        h_out_d = h_out_q;
        sub_d   = sub_q;
        rnd_d   = rnd_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    h_d        = h_in;
                    m_d        = m_in;
                    // t and f only matter at load time, so v itself holds them.
                    v_d[7:0]   = h_in;
                    v_d[15:8]  = iv_w;
                    v_d[12]    = iv_w[4] ^ t_in[W-1:0];
                    v_d[13]    = iv_w[5] ^ t_in[2*W-1:W];
                    v_d[14]    = iv_w[6] ^ {W{f_in}};
                    sub_d      = 3'd0;
                    rnd_d      = 4'd0;
                    busy_d     = 1'b1;
                    state_d    = StMix;
                end
            end
            StMix: begin
                v_d[a_sel] = ga;
                v_d[b_sel] = gb;
                v_d[c_sel] = gc;
                v_d[d_sel] = gd;
                sub_d      = sub_q + 3'd1;
                busy_d     = 1'b1;
                if (sub_q == 3'd7) begin
                    if (rnd_q == LastRnd) begin
                        // Fold on the last mix edge so h_out is valid during FINAL.
                        rnd_d   = 4'd0;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        h_out_d = h_q ^ v_d[7:0] ^ v_d[15:8];
                        state_d = StFinal;
                    end else begin
                        rnd_d = rnd_q + 4'd1;
                    end
                end
            end
            StFinal: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            h_q     <= '0;
            m_q     <= '0;
            v_q     <= '0;
            h_out_q <= '0;
            sub_q   <= '0;
            rnd_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            m_q     <= m_d;
            v_q     <= v_d;
            h_out_q <= h_out_d;
            sub_q   <= sub_d;
            rnd_q   <= rnd_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign h_out = h_out_q;
endmodule

// File: tb/tb_f_compress.sv
// Directed bench for f_compress: BLAKE2b and BLAKE2s instances driven with
// known-answer vectors ("abc", empty message), plus reset, ignored-start and
// back-to-back behaviour.

module tb_f_compress;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic          start_b, f_in_b, busy_b, done_b;
    logic [511:0]  h_in_b, h_out_b;
    logic [1023:0] m_in_b;
    logic [127:0]  t_in_b;

    logic          start_s, f_in_s, busy_s, done_s;
    logic [255:0]  h_in_s, h_out_s;
    logic [511:0]  m_in_s;
    logic [63:0]   t_in_s;

    f_compress #(.W(64), .R(12)) dut_b (
        .clk (clk), .rst (rst), .start (start_b), .h_in (h_in_b), .m_in (m_in_b),
        .t_in (t_in_b), .f_in (f_in_b), .busy (busy_b), .done (done_b), .h_out (h_out_b)
    );

    f_compress #(.W(32), .R(10)) dut_s (
        .clk (clk), .rst (rst), .start (start_s), .h_in (h_in_s), .m_in (m_in_s),
        .t_in (t_in_s), .f_in (f_in_s), .busy (busy_s), .done (done_s), .h_out (h_out_s)
    );

    localparam logic [63:0] IV [8] = '{
        64'h6a09e667f3bcc908, 64'hbb67ae8584caa73b, 64'h3c6ef372fe94f82b, 64'ha54ff53a5f1d36f1,
        64'h510e527fade682d1, 64'h9b05688c2b3e6c1f, 64'h1f83d9abfb41bd6b, 64'h5be0cd19137e2179};
    localparam logic [63:0] ABC_B [8] = '{
        64'h0D4D1C983FA580BA, 64'hE9F6129FB697276A, 64'hB7C45A68142F214C, 64'hD1A2FFDB6FBB124B,
        64'h2D79AB2A39C5877D, 64'h95CC3345DED552C2, 64'h5A92F1DBA88AD318, 64'h239900D4ED8623B9};
    localparam logic [31:0] ABC_S [8] = '{
        32'h8C5E8C50, 32'hE2147C32, 32'hA32BA7E1, 32'h2F45EB4E,
        32'h208B4537, 32'h293AD69E, 32'h4C9B994D, 32'h82596786};
    localparam logic [63:0] NUL_B0 = 64'h03590142F7026A78;
    localparam logic [63:0] NUL_B7 = 64'hCEE29BFE1A706FD5;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic load_b(input logic [63:0] m0, input logic [63:0] t);
        for (int i = 0; i < 8; i++) h_in_b[64*i +: 64] = IV[i];
        h_in_b[63:0] = IV[0] ^ 64'h01010040;
        m_in_b       = '0;
        m_in_b[63:0] = m0;
        t_in_b       = {64'd0, t};
        f_in_b       = 1'b1;
    endtask

    task automatic load_s(input logic [31:0] m0, input logic [31:0] t);
        logic [63:0] iv;
        for (int i = 0; i < 8; i++) begin
            iv = IV[i];
            h_in_s[32*i +: 32] = iv[63:32];
        end
        h_in_s[31:0] = h_in_s[31:0] ^ 32'h01010020;
        m_in_s       = '0;
        m_in_s[31:0] = m0;
        t_in_s       = {32'd0, t};
        f_in_s       = 1'b1;
    endtask

    // One-cycle start pulse; returns just after the accept edge.
    task automatic go_b();
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        #1 start_b = 1'b0;
    endtask

    task automatic go_s();
        @(negedge clk);
        start_s = 1'b1;
        @(posedge clk);
        #1 start_s = 1'b0;
    endtask

    task automatic wait_b(output int cyc, output logic busy1, output logic busy_done);
        cyc = 0;
        busy1 = 1'b0;
        do begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) busy1 = busy_b;
        end while (!done_b && cyc < 300);
        busy_done = busy_b;
    endtask

    task automatic wait_s(output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!done_s && cyc < 300);
    endtask

    int   cyc, cnt, ndone, first;
    logic busy1, busy_done;

    initial begin
        rst = 1'b1;
        start_b = 1'b0; h_in_b = '0; m_in_b = '0; t_in_b = '0; f_in_b = 1'b0;
        start_s = 1'b0; h_in_s = '0; m_in_s = '0; t_in_s = '0; f_in_s = 1'b0;
        #12;
        check("reset busy", {63'd0, busy_b}, 64'd0);
        check("reset done", {63'd0, done_b}, 64'd0);
        check("reset h_out", {63'd0, |h_out_b}, 64'd0);
        @(negedge clk);
        rst = 1'b0;

        // BLAKE2b "abc"
        load_b(64'h0000000000636261, 64'd3);
        go_b();
        wait_b(cyc, busy1, busy_done);
        check("b latency", 64'(cyc), 64'd97);
        check("b busy cycle1", {63'd0, busy1}, 64'd1);
        check("b busy at done", {63'd0, busy_done}, 64'd0);
        for (int i = 0; i < 8; i++) check($sformatf("b abc h%0d", i), h_out_b[64*i +: 64], ABC_B[i]);
        @(negedge clk);
        check("b done pulse", {63'd0, done_b}, 64'd0);
        check("b h_out held", h_out_b[63:0], ABC_B[0]);

        // BLAKE2s "abc"
        load_s(32'h00636261, 32'd3);
        go_s();
        wait_s(cyc);
        check("s latency", 64'(cyc), 64'd81);
        for (int i = 0; i < 8; i++)
            check($sformatf("s abc h%0d", i), {32'd0, h_out_s[32*i +: 32]}, {32'd0, ABC_S[i]});

        // Asynchronous reset between edges clears outputs at once.
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async rst h_out b", {63'd0, |h_out_b}, 64'd0);
        check("async rst h_out s", {63'd0, |h_out_s}, 64'd0);
        check("async rst done", {63'd0, done_b}, 64'd0);
        #1 rst = 1'b0;

        // start pulsed and inputs scrambled during MIX.
        load_b(64'h0000000000636261, 64'd3);
        go_b();
        cnt = 0;
        ndone = 0;
        while (cnt < 300 && ndone == 0) begin
            @(negedge clk);
            cnt++;
            if (done_b) ndone++;
            else if (cnt < 90) begin
                start_b      = cnt[0];
                h_in_b       = {16{$urandom()}};
                m_in_b[63:0] = {$urandom(), $urandom()};
            end else start_b = 1'b0;
        end
        start_b = 1'b0;
        check("ignore start latency", 64'(cnt), 64'd97);
        check("ignore start h0", h_out_b[63:0], ABC_B[0]);
        check("ignore start h7", h_out_b[511:448], ABC_B[7]);
        ndone = 0;
        repeat (110) begin
            @(negedge clk);
            if (done_b) ndone++;
        end
        check("ignore start extra done", 64'(ndone), 64'd0);

        // Abort at cycle 40, then a fresh job.
        load_b(64'h0000000000636261, 64'd3);
        go_b();
        ndone = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_b) ndone++;
        end
        #2 rst = 1'b1;
        #2 rst = 1'b0;
        check("abort busy", {63'd0, busy_b}, 64'd0);
        repeat (120) begin
            @(negedge clk);
            if (done_b) ndone++;
        end
        check("abort no done", 64'(ndone), 64'd0);
        go_b();
        wait_b(cyc, busy1, busy_done);
        check("after abort latency", 64'(cyc), 64'd97);
        check("after abort h0", h_out_b[63:0], ABC_B[0]);
        check("after abort h7", h_out_b[511:448], ABC_B[7]);

        // start held high: back-to-back jobs.
        @(negedge clk);
        start_b = 1'b1;
        @(posedge clk);
        cnt = 0;
        ndone = 0;
        first = 0;
        while (cnt < 400 && ndone < 2) begin
            @(negedge clk);
            cnt++;
            if (done_b) begin
                ndone++;
                check($sformatf("held job%0d h0", ndone), h_out_b[63:0], ABC_B[0]);
                check($sformatf("held job%0d h7", ndone), h_out_b[511:448], ABC_B[7]);
                if (ndone == 1) first = cnt;
                else begin
                    start_b = 1'b0;
                    check("held gap", 64'(cnt - first), 64'd98);
                end
            end
        end
        start_b = 1'b0;
        check("held first latency", 64'(first), 64'd97);
        check("held done count", 64'(ndone), 64'd2);
        repeat (3) @(negedge clk);

        // BLAKE2b of the empty message.
        load_b(64'd0, 64'd0);
        go_b();
        wait_b(cyc, busy1, busy_done);
        check("b empty latency", 64'(cyc), 64'd97);
        check("b empty h0", h_out_b[63:0], NUL_B0);
        check("b empty h7", h_out_b[511:448], NUL_B7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
